// File: rtl/ca_pkg.sv
// Shared definitions for the cellular-automaton frame control slice:
// mode encodings, the two rules used by ALT mode, and the LFSR step.
package ca_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_ALT    = 2'd1,
    MODE_CYCLE  = 2'd2,
    MODE_RANDOM = 2'd3
  } ca_mode_e;

  localparam logic [7:0]  RULE_30   = 8'd30;
  localparam logic [7:0]  RULE_110  = 8'd110;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One Galois step; an all-zero state is a lock-up, so it is kicked to 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    logic [15:0] nxt;
    if (state == 16'h0000) begin
      nxt = 16'h0001;
    end else begin
      nxt = {1'b0, state[15:1]} ^ (state[0] ? LFSR_MASK : 16'h0000);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ca_debounce.sv
// Reseed button conditioner: 2-FF synchroniser followed by a counter that
// only looks at the button once per frame. A new level is accepted after
// DEBOUNCE_FRAMES consecutive frame samples disagree with the stable level.
module ca_debounce #(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic btn_async,
  output logic btn_stable,
  output logic btn_rise
);

  localparam int CW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic          btn_s1;
  logic          btn_s2;
  logic [CW-1:0] db_cnt;
  logic          differs;
  logic          accept;

  assign differs  = btn_s2 ^ btn_stable;
  assign accept   = frame_tick & differs & (db_cnt == CNT_LAST);
  assign btn_rise = accept & btn_s2;

  // Bring the raw pushbutton into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_async;
      btn_s2 <= btn_s1;
    end
  end

  // Count consecutive disagreeing frame samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_stable <= 1'b0;
      db_cnt     <= '0;
    end else if (frame_tick) begin
      if (differs) begin
        if (db_cnt == CNT_LAST) begin
          btn_stable <= btn_s2;
          db_cnt     <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ca_frame_ctrl.sv
// Per-frame control for the CA renderer: picks the Wolfram rule in one of
// four modes and raises a one-frame init strobe with a latched seed word.
// Everything visible to the renderer changes only on the leading vsync edge.
module ca_frame_ctrl
  import ca_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES      = 60,
  parameter int unsigned DEBOUNCE_FRAMES  = 3,
  parameter logic [7:0]  DEFAULT_RULE     = 8'd30,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
  parameter bit          RESEED_ON_RULE   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [7:0]  sw_rule,
  input  logic [1:0]  sw_mode,
  input  logic        btn_reseed,
  output logic [7:0]  rule,
  output logic        init,
  output logic [15:0] seed,
  output logic [1:0]  mode,
  output logic [11:0] frame_cnt
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  logic [7:0]    rule_s1, rule_s2;
  logic [1:0]    mode_s1, mode_s2;
  logic          vsync_act, vsync_d, frame_tick;
  logic [15:0]   lfsr;
  logic          btn_stable, btn_rise, btn_req;

  logic [7:0]    rule_q, rule_nxt;
  ca_mode_e      mode_q, mode_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          init_q;
  logic [15:0]   seed_q;
  logic [11:0]   frame_q;
  logic          mode_change, advance, reseed_req;

  assign vsync_act  = vsync ^ VSYNC_ACTIVE_LOW;
  assign frame_tick = vsync_act & ~vsync_d;

  // A button rise only counts when the accepted level was low going in.
  assign btn_req = btn_rise & ~btn_stable;

  ca_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_async  (btn_reseed),
    .btn_stable (btn_stable),
    .btn_rise   (btn_rise)
  );

  // Synchronise the switches and remember last vsync for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rule_s1 <= '0;
      rule_s2 <= '0;
      mode_s1 <= '0;
      mode_s2 <= '0;
      vsync_d <= 1'b0;
    end else begin
      rule_s1 <= sw_rule;
      rule_s2 <= rule_s1;
      mode_s1 <= sw_mode;
      mode_s2 <= mode_s1;
      vsync_d <= vsync_act;
    end
  end

  // Free-running LFSR, advanced every clock so seeds differ frame to frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Decide next rule/mode/hold; a mode change wins over a same-frame advance.
  always_comb begin
    mode_change = (mode_s2 != mode_q);
    advance     = (hold_cnt == HOLD_LAST);
    mode_nxt    = mode_q;
    hold_nxt    = advance ? '0 : hold_cnt + 1'b1;
    rule_nxt    = rule_q;
    if (mode_change) begin
      mode_nxt = ca_mode_e'(mode_s2);
      hold_nxt = '0;
      case (mode_nxt)
        MODE_MANUAL: rule_nxt = rule_s2;
        MODE_ALT:    rule_nxt = RULE_30;
        MODE_CYCLE:  rule_nxt = rule_q;
        MODE_RANDOM: rule_nxt = lfsr[7:0];
        default:     rule_nxt = rule_q;
      endcase
    end else begin
      case (mode_q)
        MODE_MANUAL: rule_nxt = rule_s2;
        MODE_ALT:    if (advance) rule_nxt = (rule_q == RULE_30) ? RULE_110 : RULE_30;
        MODE_CYCLE:  if (advance) rule_nxt = rule_q + 8'd1;
        MODE_RANDOM: if (advance) rule_nxt = lfsr[7:0];
        default:     rule_nxt = rule_q;
      endcase
    end
    reseed_req = btn_req | mode_change | (RESEED_ON_RULE && (rule_nxt != rule_q));
  end

  // Commit all renderer-facing state at the frame boundary only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rule_q   <= DEFAULT_RULE;
      mode_q   <= MODE_MANUAL;
      hold_cnt <= '0;
      init_q   <= 1'b1;
      seed_q   <= LFSR_SEED;
      frame_q  <= '0;
    end else if (frame_tick) begin
      rule_q   <= rule_nxt;
      mode_q   <= mode_nxt;
      hold_cnt <= hold_nxt;
      init_q   <= reseed_req;
      if (reseed_req) begin
        seed_q <= lfsr;
      end
      frame_q  <= frame_q + 12'd1;
    end
  end

  assign rule      = rule_q;
  assign mode      = mode_q;
  assign init      = init_q;
  assign seed      = seed_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_ca_frame_ctrl.sv
// Self-checking bench for ca_frame_ctrl: a frame-level behavioural model
// tracks the expected outputs and is compared every cycle, with directed
// scenarios pinning literal values and a randomized tail.
module tb_ca_frame_ctrl;

  localparam int HOLD       = 4;
  localparam int DEB        = 3;
  localparam int FRAME_CLKS = 24;
  localparam int VS_LEN     = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b1;
  logic [7:0]  sw_rule = 8'd30;
  logic [1:0]  sw_mode = 2'd0;
  logic        btn_reseed = 1'b0;
  logic [7:0]  rule;
  logic        init;
  logic [15:0] seed;
  logic [1:0]  mode;
  logic [11:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int tick_count = 0;

  logic [15:0] m_lfsr, m_seed;
  logic [7:0]  m_rule;
  logic [1:0]  m_mode;
  logic        m_init, m_stable, m_vd;
  int          m_fc, m_hold, m_db;
  logic [7:0]  r1, r2;
  logic [1:0]  md1, md2;
  logic        b1, b2;

  ca_frame_ctrl #(
    .HOLD_FRAMES(HOLD),
    .DEBOUNCE_FRAMES(DEB),
    .DEFAULT_RULE(8'd30),
    .LFSR_SEED(16'hACE1),
    .VSYNC_ACTIVE_LOW(1'b1),
    .RESEED_ON_RULE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .sw_rule(sw_rule),
    .sw_mode(sw_mode), .btn_reseed(btn_reseed), .rule(rule), .init(init),
    .seed(seed), .mode(mode), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Timing generator stand-in: active-low vsync pulse once per frame.
  initial begin
    forever begin
      repeat (FRAME_CLKS - VS_LEN) @(negedge clk);
      vsync = 1'b0;
      repeat (VS_LEN) @(negedge clk);
      vsync = 1'b1;
    end
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    if (s == 16'h0000) return 16'h0001;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] r, input logic b);
    sw_mode    = m;
    sw_rule    = r;
    btn_reseed = b;
  endtask

  // What one frame boundary does, expressed as frame-level rules.
  task automatic model_frame();
    logic       req;
    logic [7:0] nr;
    bit         adv;
    req = 1'b0;
    nr  = m_rule;
    if (b2 != m_stable) begin
      m_db = m_db + 1;
      if (m_db >= DEB) begin
        m_stable = b2;
        m_db     = 0;
        if (b2) req = 1'b1;
      end
    end else begin
      m_db = 0;
    end
    if (md2 != m_mode) begin
      m_mode = md2;
      m_hold = 0;
      case (md2)
        2'd0: nr = r2;
        2'd1: nr = 8'd30;
        2'd2: nr = m_rule;
        default: nr = m_lfsr[7:0];
      endcase
      req = 1'b1;
    end else begin
      m_hold = m_hold + 1;
      adv = (m_hold == HOLD);
      if (adv) m_hold = 0;
      case (m_mode)
        2'd0: nr = r2;
        2'd1: if (adv) nr = (m_rule == 8'd30) ? 8'd110 : 8'd30;
        2'd2: if (adv) nr = m_rule + 8'd1;
        default: if (adv) nr = m_lfsr[7:0];
      endcase
    end
    if (nr != m_rule) req = 1'b1;
    m_rule = nr;
    m_init = req;
    if (req) m_seed = m_lfsr;
    m_fc = m_fc + 1;
    tick_count++;
  endtask

  // Reference model, stepped on every clock and reset asynchronously.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_lfsr = 16'hACE1; m_seed = 16'hACE1; m_rule = 8'd30; m_mode = 2'd0;
        m_init = 1'b1; m_stable = 1'b0; m_vd = 1'b0; m_fc = 0; m_hold = 0; m_db = 0;
        r1 = '0; r2 = '0; md1 = '0; md2 = '0; b1 = 1'b0; b2 = 1'b0;
      end else begin
        if (~vsync && !m_vd) model_frame();
        m_vd   = ~vsync;
        r2 = r1;  r1 = sw_rule;
        md2 = md1; md1 = sw_mode;
        b2 = b1;  b1 = btn_reseed;
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checkOutput("cmp_rule", rule, m_rule);
        checkOutput("cmp_mode", mode, m_mode);
        checkOutput("cmp_init", init, m_init);
        checkOutput("cmp_seed", seed, m_seed);
        checkOutput("cmp_frame_cnt", frame_cnt, m_fc & 32'hFFF);
      end
    end
  end

  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = tick_count + n;
    budget = n * FRAME_CLKS * 3;
    while (tick_count < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (tick_count < target) checkOutput("frame_wait_timeout", tick_count, target);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_rule"}, rule, 8'd30);
    checkOutput({tag, "_init"}, init, 1'b1);
    checkOutput({tag, "_seed"}, seed, 16'hACE1);
    checkOutput({tag, "_mode"}, mode, 2'd0);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, 12'd0);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n_init;
    int first_f;
    logic [15:0] seed_seen;

    // Power-on reset and the first two frames.
    repeat (3) @(posedge clk);
    #3 cmp_en = 1'b1;
    check_reset_values("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_frames(2);
    checkOutput("frame2_cnt", frame_cnt, 12'd2);
    checkOutput("frame2_init", init, 1'b0);
    checkOutput("frame2_rule", rule, 8'd30);

    // ALT: 30 on entry, 110 after HOLD frames, back to 30 after another HOLD.
    $display("[TB] ALT mode");
    applyStimulus(2'd1, 8'd30, 1'b0);
    wait_frames(1);
    checkOutput("alt_enter_mode", mode, 2'd1);
    checkOutput("alt_enter_rule", rule, 8'd30);
    checkOutput("alt_enter_init", init, 1'b1);
    wait_frames(3);
    checkOutput("alt_hold_init", init, 1'b0);
    wait_frames(1);
    checkOutput("alt_adv1_rule", rule, 8'd110);
    checkOutput("alt_adv1_init", init, 1'b1);
    wait_frames(1);
    checkOutput("alt_after_init", init, 1'b0);
    wait_frames(3);
    checkOutput("alt_adv2_rule", rule, 8'd30);

    // MANUAL: switch change mid-frame only shows at the next frame.
    $display("[TB] MANUAL mode");
    applyStimulus(2'd0, 8'd30, 1'b0);
    wait_frames(2);
    repeat (8) @(negedge clk);
    applyStimulus(2'd0, 8'd90, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("manual_midframe_rule", rule, 8'd30);
    wait_frames(1);
    checkOutput("manual_new_rule", rule, 8'd90);
    checkOutput("manual_new_init", init, 1'b1);

    // CYCLE from 254: wraps through 255 to 0, ignoring sw_rule.
    $display("[TB] CYCLE mode");
    applyStimulus(2'd0, 8'd254, 1'b0);
    wait_frames(1);
    applyStimulus(2'd2, 8'd7, 1'b0);
    wait_frames(1);
    checkOutput("cycle_enter_rule", rule, 8'd254);
    wait_frames(4);
    checkOutput("cycle_adv1_rule", rule, 8'd255);
    checkOutput("cycle_adv1_init", init, 1'b1);
    wait_frames(4);
    checkOutput("cycle_wrap_rule", rule, 8'd0);
    checkOutput("cycle_wrap_init", init, 1'b1);

    // Button: short glitches never seed; a held press seeds exactly once.
    $display("[TB] button");
    applyStimulus(2'd0, 8'd0, 1'b0);
    wait_frames(2);
    for (int g = 0; g < 4; g++) begin
      repeat (6) @(negedge clk);
      btn_reseed = 1'b1;
      repeat (3) @(negedge clk);
      btn_reseed = 1'b0;
      wait_frames(1);
      checkOutput("glitch_init", init, 1'b0);
    end
    btn_reseed = 1'b1;
    n_init = 0; first_f = 0; seed_seen = '0;
    for (int f = 1; f <= 5; f++) begin
      wait_frames(1);
      if (init) begin
        n_init++;
        first_f   = f;
        seed_seen = seed;
      end
    end
    checkOutput("btn_init_frames", n_init, 1);
    checkOutput("btn_init_at_frame", first_f, 3);
    checkOutput("btn_seed_nonzero", (seed_seen != 16'h0), 1'b1);
    btn_reseed = 1'b0;
    wait_frames(4);

    // RANDOM, then a mode change landing on an advance frame.
    $display("[TB] RANDOM mode");
    applyStimulus(2'd3, 8'd0, 1'b0);
    wait_frames(1);
    checkOutput("random_enter_mode", mode, 2'd3);
    for (int k = 0; k < HOLD + 1; k++) begin
      if (m_hold == HOLD - 1) break;
      wait_frames(1);
    end
    applyStimulus(2'd1, 8'd0, 1'b0);
    wait_frames(1);
    checkOutput("override_mode", mode, 2'd1);
    checkOutput("override_rule", rule, 8'd30);
    applyStimulus(2'd3, 8'd0, 1'b0);
    wait_frames(2);
    repeat (7) @(negedge clk);
    pulseReset();
    wait_frames(1);
    checkOutput("post_reset_mode", mode, 2'd3);
    checkOutput("post_reset_init", init, 1'b1);

    // Randomized tail checked by the model.
    $display("[TB] random stimulus");
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) sw_mode = 2'($urandom_range(0, 3));
      sw_rule = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 20)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) btn_reseed = ~btn_reseed;
      wait_frames(1);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
